mux_arbiter: RTL and testbench

Parametrised N-channel registered multiplexer with valid/ready handshake, the successor to the CPU's combinational 32:1 select mux. It selects one channel per cycle, either by an explicit select code (fixed mode) or by round-robin arbitration among requesting channels, and holds the chosen word in a one-entry output register. It sits between multiple producers (register-file read sources, forwarding paths, bus masters) and a single consumer that may stall.

---
 rtl/mux_arbiter.sv | 96 +++++++++
 tb/tb_mux_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// mux_arbiter: N-channel registered multiplexer with valid/ready handshake.
// Picks one channel per cycle, either by explicit select (fixed mode) or by
// round-robin among requesting channels, into a one-entry output register.
module mux_arbiter #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         in_valid,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  output logic [CHANNELS-1:0]         in_ready,
  input  logic                        rr_mode,
  input  logic [$clog2(CHANNELS)-1:0] sel,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(CHANNELS)-1:0] out_chan,
  input  logic                        out_ready
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W:0]   CH_LIM  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_chan;
  logic [SEL_W-1:0] r_ptr;

  logic             w_can_load;
  logic             w_sel_ok;
  logic             w_fix_ok;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_grant;
  logic [SEL_W-1:0] w_gidx;
  logic [WIDTH-1:0] w_gdata;

  // The register can take a new word when empty or when it drains this cycle.
  assign w_can_load = !r_out_valid || out_ready;
  // Select codes beyond the last channel never grant.
  assign w_sel_ok   = {1'b0, sel} < CH_LIM;
  assign w_fix_ok   = w_sel_ok && in_valid[sel];

  // Round-robin search: first requesting channel starting at ptr, wrapping.
  always_comb begin
    int idx;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    idx        = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!w_rr_found && in_valid[idx[SEL_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = idx[SEL_W-1:0];
      end
    end
  end

  assign w_grant = w_can_load && (rr_mode ? w_rr_found : w_fix_ok);
  assign w_gidx  = rr_mode ? w_rr_idx : sel;

  // Data mux for the granted channel; only reaches flops, never an output.
  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_gidx == SEL_W'(i)) w_gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  // One-hot grant, suppressed while reset is asserted.
  assign in_ready = (w_grant && !rst) ? (CHANNELS'(1) << w_gidx) : '0;

  // Output register and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gdata;
      r_out_chan  <= w_gidx;
      if (rr_mode) r_ptr <= (w_gidx == CH_LAST) ? '0 : w_gidx + 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: three instances (32, 4 and 6 channels).
module tb_mux_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 32-channel instance (fixed mode)
  logic [31:0]      v32, r32;
  logic [32*32-1:0] d32;
  logic             m32, ov32, or32;
  logic [4:0]       s32, oc32;
  logic [31:0]      od32;
  // 4-channel instance (round robin, backpressure, reset)
  logic [3:0]       v4, r4;
  logic [4*32-1:0]  d4;
  logic             m4, ov4, or4;
  logic [1:0]       s4, oc4;
  logic [31:0]      od4;
  // 6-channel instance (wrap, illegal select)
  logic [5:0]       v6, r6;
  logic [6*32-1:0]  d6;
  logic             m6, ov6, or6;
  logic [2:0]       s6, oc6;
  logic [31:0]      od6;

  mux_arbiter #(.WIDTH(32), .CHANNELS(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_data(d32), .in_ready(r32),
    .rr_mode(m32), .sel(s32), .out_valid(ov32), .out_data(od32),
    .out_chan(oc32), .out_ready(or32));

  mux_arbiter #(.WIDTH(32), .CHANNELS(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(r4),
    .rr_mode(m4), .sel(s4), .out_valid(ov4), .out_data(od4),
    .out_chan(oc4), .out_ready(or4));

  mux_arbiter #(.WIDTH(32), .CHANNELS(6)) u6 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_data(d6), .in_ready(r6),
    .rr_mode(m6), .sel(s6), .out_valid(ov6), .out_data(od6),
    .out_chan(oc6), .out_ready(or6));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp4 [6];
    int alt4 [4];
    exp4 = '{0, 1, 2, 3, 0, 1};
    alt4 = '{3, 0, 3, 0};

    for (int i = 0; i < 32; i++) d32[i*32 +: 32] = 32'h01010101 * i;
    d32[5*32 +: 32] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) d4[i*32 +: 32] = 32'hA0 + i;
    for (int i = 0; i < 6; i++) d6[i*32 +: 32] = 32'hC0 + i;

    rst = 1'b1;
    v32 = '1; m32 = 1'b0; s32 = 5'd5; or32 = 1'b1;
    v4  = '1; m4  = 1'b1; s4  = '0;   or4  = 1'b1;
    v6  = '1; m6  = 1'b1; s6  = '0;   or6  = 1'b1;

    // reset with every channel requesting
    tick(); tick();
    check("rst_rdy32", r32, 0);
    check("rst_rdy4",  r4,  0);
    check("rst_rdy6",  r6,  0);
    check("rst_ov32",  ov32, 0);
    check("rst_od32",  od32, 0);
    check("rst_oc32",  oc32, 0);
    check("rst_ov4",   ov4, 0);

    // fixed mode on 32 channels
    v4 = '0; v6 = '0;
    rst = 1'b0;
    #1;
    check("fix_rdy", r32, 32'h20);
    tick();
    check("fix_ov", ov32, 1);
    check("fix_od", od32, 32'hDEADBEEF);
    check("fix_oc", oc32, 5);
    v32[5] = 1'b0;
    #1;
    check("fix_norq_rdy", r32, 0);
    tick();
    check("fix_norq_ov", ov32, 0);

    // round robin on 4 channels, all requesting
    v4 = 4'b1111;
    #1;
    check("rr_first_rdy", r4, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_ov", ov4, 1);
      check("rr_oc", oc4, exp4[k]);
      check("rr_od", od4, 32'hA0 + exp4[k]);
    end
    // two requesters, pointer now at 2
    v4 = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_alt_oc", oc4, alt4[k]);
    end

    // backpressure: word from channel 0 held, pointer at 1
    v4 = 4'b1111; or4 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rdy", r4, 0);
      tick();
      check("bp_ov", ov4, 1);
      check("bp_od", od4, 32'hA0);
    end
    or4 = 1'b1;
    #1;
    check("bp_rel_rdy", r4, 4'b0010);
    tick();
    check("bp_rel_ov", ov4, 1);
    check("bp_rel_oc", oc4, 1);
    check("bp_rel_od", od4, 32'hA1);

    // drain without refill keeps last data/chan
    v4 = '0;
    tick();
    check("drain_ov", ov4, 0);
    check("drain_od", od4, 32'hA1);
    check("drain_oc", oc4, 1);

    // wrap on 6 channels
    v6 = 6'b100000;
    #1;
    check("wrap_rdy5", r6, 6'b100000);
    tick();
    check("wrap_oc5", oc6, 5);
    check("wrap_od5", od6, 32'hC5);
    v6 = 6'b100001;
    #1;
    check("wrap_rdy0", r6, 6'b000001);
    tick();
    check("wrap_oc0", oc6, 0);
    v6 = 6'b000100;
    #1;
    check("wrap_rdy2", r6, 6'b000100);
    tick();
    check("wrap_oc2", oc6, 2);

    // fixed and illegal selects on 6 channels; pointer stays at 3
    m6 = 1'b0; s6 = 3'd3; v6 = '1;
    #1;
    check("fix6_rdy", r6, 6'b001000);
    tick();
    check("fix6_oc", oc6, 3);
    s6 = 3'd7;
    #1;
    check("sel7_rdy", r6, 0);
    tick();
    check("sel7_ov", ov6, 0);
    s6 = 3'd6;
    #1;
    check("sel6_rdy", r6, 0);
    m6 = 1'b1;
    #1;
    check("ptr_kept_rdy", r6, 6'b001000);
    tick();
    v6 = '0;

    // reset mid-operation with a held word (4-channel pointer at 2)
    v4 = 4'b1111; or4 = 1'b1;
    tick();
    check("mid_oc", oc4, 2);
    or4 = 1'b0;
    tick();
    check("mid_hold_ov", ov4, 1);
    rst = 1'b1; or4 = 1'b1;
    #1;
    check("mid_rst_rdy", r4, 0);
    tick();
    check("mid_rst_ov", ov4, 0);
    check("mid_rst_od", od4, 0);
    check("mid_rst_oc", oc4, 0);
    rst = 1'b0;
    #1;
    check("mid_restart_rdy", r4, 4'b0001);
    tick();
    check("mid_restart_oc", oc4, 0);
    check("mid_restart_ov", ov4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
